// File: rtl/add_table_ram_ctrl.sv
// Sum-table fill sequencer and round-robin read arbiter
// for the OPW-bit adder lookup SRAM.
module add_table_ram_ctrl #(
  parameter int OPW           = 4,
  parameter bit FILL_ON_RESET = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             READY,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [OPW-1:0]   A0,
  input  logic [OPW-1:0]   B0,
  input  logic [OPW-1:0]   A1,
  input  logic [OPW-1:0]   B1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             VALID0,
  output logic             VALID1,
  output logic [OPW:0]     DOUT0,
  output logic [OPW:0]     DOUT1,
  output logic             RAM_CS,
  output logic             RAM_WE,
  output logic [2*OPW-1:0] RAM_ADDR,
  output logic [OPW:0]     RAM_DIN,
  input  logic [OPW:0]     RAM_DOUT
);

  localparam int AW = 2 * OPW;
  localparam int DW = OPW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_SERVE = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_CAPT  = 3'd4;
  localparam logic [2:0] S_RST   = FILL_ON_RESET ? S_FILL : S_IDLE;

  localparam logic [AW:0] CNT_ONE = 1;

  logic [2:0]    state_q, state_d;
  // Extra MSB marks that the last address has already been written.
  logic [AW:0]   cnt_q, cnt_d;
  logic          rr_q, rr_d;
  logic          sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          v0_q, v0_d;
  logic          v1_q, v1_d;
  logic [DW-1:0] dout0_q, dout0_d;
  logic [DW-1:0] dout1_q, dout1_d;
  logic          cs_q, cs_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          start_fill;
  logic          pick;

  function automatic logic [DW-1:0] fsum(
    input logic [AW-1:0] idx
  );
    return {1'b0, idx[AW-1:OPW]}
         + {1'b0, idx[OPW-1:0]};
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    sel_d      = sel_q;
    done_d     = 1'b0;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    v0_d       = 1'b0;
    v1_d       = 1'b0;
    dout0_d    = dout0_q;
    dout1_d    = dout1_q;
    cs_d       = 1'b0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    start_fill = 1'b0;
    pick       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        start_fill = START;
      end
      S_FILL: begin
        if (cnt_q[AW]) begin
          state_d = S_SERVE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cs_d   = 1'b1;
          we_d   = 1'b1;
          addr_d = cnt_q[AW-1:0];
          din_d  = fsum(cnt_q[AW-1:0]);
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      S_SERVE: begin
        if (START) begin
          start_fill = 1'b1;
        end else if (REQ0 || REQ1) begin
          // On contention the last winner yields.
          pick    = (REQ0 && REQ1) ? ~rr_q : REQ1;
          cs_d    = 1'b1;
          addr_d  = pick ? {A1, B1} : {A0, B0};
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          rr_d    = pick;
          sel_d   = pick;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        if (sel_q) begin
          v1_d    = 1'b1;
          dout1_d = RAM_DOUT;
        end else begin
          v0_d    = 1'b1;
          dout0_d = RAM_DOUT;
        end
        state_d = S_SERVE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Entering FILL already issues the write of address 0.
    if (start_fill) begin
      state_d = S_FILL;
      cs_d    = 1'b1;
      we_d    = 1'b1;
      addr_d  = '0;
      din_d   = '0;
      cnt_d   = CNT_ONE;
    end
    busy_d  = (state_d == S_FILL);
    ready_d = (state_d == S_SERVE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      rr_q    <= 1'b1;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      dout0_q <= '0;
      dout1_q <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign READY    = ready_q;
  assign GNT0     = gnt0_q;
  assign GNT1     = gnt1_q;
  assign VALID0   = v0_q;
  assign VALID1   = v1_q;
  assign DOUT0    = dout0_q;
  assign DOUT1    = dout1_q;
  assign RAM_CS   = cs_q;
  assign RAM_WE   = we_q;
  assign RAM_ADDR = addr_q;
  assign RAM_DIN  = din_q;

endmodule

// File: tb/tb_add_table_ram_ctrl.sv
// Directed bench for add_table_ram_ctrl with a
// behavioural 256x5 synchronous SRAM.
module tb_add_table_ram_ctrl;

  logic       CLK = 1'b0;
  logic       RST, START;
  logic       BUSY, DONE, READY;
  logic       REQ0, REQ1;
  logic [3:0] A0, B0, A1, B1;
  logic       GNT0, GNT1, VALID0, VALID1;
  logic [4:0] DOUT0, DOUT1;
  logic       RAM_CS, RAM_WE;
  logic [7:0] RAM_ADDR;
  logic [4:0] RAM_DIN, RAM_DOUT;

  logic [4:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int vld_cnt = 0;
  int g0_cnt = 0;
  int g1_cnt = 0;

  add_table_ram_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START),
    .BUSY(BUSY), .DONE(DONE), .READY(READY),
    .REQ0(REQ0), .REQ1(REQ1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .GNT0(GNT0), .GNT1(GNT1),
    .VALID0(VALID0), .VALID1(VALID1),
    .DOUT0(DOUT0), .DOUT1(DOUT1),
    .RAM_CS(RAM_CS), .RAM_WE(RAM_WE),
    .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN),
    .RAM_DOUT(RAM_DOUT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RAM_CS && RAM_WE) mem[RAM_ADDR] <= RAM_DIN;
    if (RAM_CS && !RAM_WE) RAM_DOUT <= mem[RAM_ADDR];
    else RAM_DOUT <= 'x;
  end

  always @(posedge CLK) begin
    if (RAM_CS && RAM_WE) wr_cnt <= wr_cnt + 1;
    if (VALID0 || VALID1) vld_cnt <= vld_cnt + 1;
    if (GNT0) g0_cnt <= g0_cnt + 1;
    if (GNT1) g1_cnt <= g1_cnt + 1;
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_fill(output int busy_n);
    int n;
    busy_n = 0;
    n = 0;
    while (DONE !== 1'b1 && n < 400) begin
      if (BUSY === 1'b1) busy_n++;
      tick();
      n++;
    end
  endtask

  initial begin
    int bn, w0, gs0, gs1, vs, err;
    logic eg0, eg1, ev0, ev1;
    RST = 1'b1; START = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    @(negedge CLK);
    tick(); tick();
    chk("rst_busy", BUSY, 0);
    chk("rst_ready", READY, 0);
    chk("rst_cs", RAM_CS, 0);
    chk("rst_addr", RAM_ADDR, 0);
    chk("rst_dout0", DOUT0, 0);

    RST = 1'b0;
    REQ1 = 1'b1; A1 = 4'd15; B1 = 4'd15;
    gs1 = g1_cnt;
    tick(); tick(); tick();
    chk("idle_no_gnt1", g1_cnt - gs1, 0);
    chk("idle_ready", READY, 0);
    REQ1 = 1'b0;

    w0 = wr_cnt;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("fill_busy", BUSY, 1);
    chk("fill_first_cs", RAM_CS, 1);
    chk("fill_first_addr", RAM_ADDR, 0);
    run_fill(bn);
    chk("fill_busy_cycles", bn, 256);
    chk("fill_done", DONE, 1);
    chk("fill_writes", wr_cnt - w0, 256);
    chk("fill_cs_off", RAM_CS, 0);
    tick();
    chk("done_pulse", DONE, 0);
    chk("ready_after", READY, 1);
    chk("mem_00", mem[8'h00], 5'd0);
    chk("mem_23", mem[8'h23], 5'd5);
    chk("mem_ff", mem[8'hFF], 5'h1E);

    A0 = 4'd3; B0 = 4'd3; A1 = 4'd2; B1 = 4'd7;
    REQ0 = 1'b1; REQ1 = 1'b1;
    err = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      eg0 = (i == 1 || i == 7);
      eg1 = (i == 4 || i == 10);
      ev0 = (i == 3 || i == 9);
      ev1 = (i == 6 || i == 12);
      if (GNT0 !== eg0 || GNT1 !== eg1) err++;
      if (VALID0 !== ev0 || VALID1 !== ev1) err++;
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    chk("rr_pattern_errs", err, 0);
    chk("rr_dout0", DOUT0, 5'd6);
    chk("rr_dout1", DOUT1, 5'd9);
    tick();
    chk("rr_ready", READY, 1);

    A0 = 4'd2; B0 = 4'd3; REQ0 = 1'b1;
    tick();
    REQ0 = 1'b0;
    chk("s_gnt0", GNT0, 1);
    chk("s_addr", RAM_ADDR, 8'h23);
    chk("s_we", RAM_WE, 0);
    tick();
    chk("s_gnt0_off", GNT0, 0);
    tick();
    chk("s_valid0", VALID0, 1);
    chk("s_dout0", DOUT0, 5'd5);
    chk("s_valid1", VALID1, 0);
    chk("s_dout1_kept", DOUT1, 5'd9);
    tick();
    chk("s_valid0_off", VALID0, 0);

    START = 1'b1; REQ0 = 1'b1; A0 = 4'd2; B0 = 4'd3;
    REQ1 = 1'b1; A1 = 4'd15; B1 = 4'd15;
    tick();
    START = 1'b0;
    gs0 = g0_cnt; gs1 = g1_cnt;
    chk("sr_no_gnt0", GNT0, 0);
    chk("sr_busy", BUSY, 1);
    run_fill(bn);
    chk("sr_busy_cycles", bn, 256);
    chk("sr_no_gnts", (g0_cnt - gs0) + (g1_cnt - gs1), 0);
    tick();
    chk("sr_gnt1", GNT1, 1);
    REQ1 = 1'b0;
    tick(); tick();
    chk("sr_valid1", VALID1, 1);
    chk("sr_dout1", DOUT1, 5'h1E);
    tick();
    chk("sr_gnt0", GNT0, 1);
    REQ0 = 1'b0;
    tick(); tick();
    chk("sr_valid0", VALID0, 1);
    chk("sr_dout0", DOUT0, 5'd5);
    tick();

    A0 = 4'd3; B0 = 4'd3; REQ0 = 1'b1;
    tick();
    chk("ri_gnt0", GNT0, 1);
    REQ0 = 1'b0; RST = 1'b1;
    vs = vld_cnt;
    tick();
    chk("ri_gnt0_off", GNT0, 0);
    chk("ri_cs", RAM_CS, 0);
    chk("ri_ready", READY, 0);
    chk("ri_dout0", DOUT0, 0);
    chk("ri_dout1", DOUT1, 0);
    RST = 1'b0;
    tick(); tick(); tick();
    chk("ri_no_valid", vld_cnt - vs, 0);
    chk("ri_ready_low", READY, 0);

    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("rf_addr100", RAM_ADDR, 8'd100);
    chk("rf_busy", BUSY, 1);
    RST = 1'b1;
    tick();
    chk("rf_busy_off", BUSY, 0);
    chk("rf_cs", RAM_CS, 0);
    chk("rf_we", RAM_WE, 0);
    chk("rf_addr", RAM_ADDR, 0);
    RST = 1'b0;
    tick(); tick(); tick();
    chk("rf_idle_ready", READY, 0);
    chk("rf_idle_busy", BUSY, 0);
    START = 1'b1;
    tick();
    START = 1'b0;
    run_fill(bn);
    chk("rf_refill_cycles", bn, 256);
    tick();
    chk("rf_ready", READY, 1);
    chk("rf_mem_ff", mem[8'hFF], 5'h1E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
